// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hub75_pkg
// Desc     : Shared types and constants for the HUB75 framebuffer path.
// Revision : 1.0 - initial release
// ============================================================================
package hub75_pkg;

    // One bank holds a single 64x64 frame.
    localparam int FRAME_SIZE = 64 * 64;
    localparam int FB_ADDR_W  = $clog2(FRAME_SIZE);
    // Two scan segments x three colours x 8 bits per colour.
    localparam int FB_DATA_W  = 48;

    // Bank-swap state machine encoding.
    typedef enum logic [0:0] {
        SW_IDLE = 1'b0,
        SW_PEND = 1'b1
    } hub75_swap_state_t;

endpackage : hub75_pkg
`default_nettype wire

// File: rtl/hub75_fb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hub75_fb_scheduler
// Desc     : Shares one single-port double-banked framebuffer RAM between the
//            HUB75 scan engine (front-bank reads, highest priority) and a host
//            pixel writer (back-bank writes). Front/back are exchanged only at
//            frame boundaries; the display is held off until the first frame
//            has been published.
// Revision : 1.0 - initial release
// ============================================================================
module hub75_fb_scheduler
    import hub75_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    // Scan-engine read port
    input  logic              disp_rd_en,
    input  logic [ADDR_W-1:0] disp_rd_addr,
    output logic [DATA_W-1:0] disp_rd_data,
    output logic              disp_rd_valid,
    input  logic              disp_frame_done,
    output logic              disp_enable,
    // Host write port
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic              host_swap_req,
    output logic              host_swap_pending,
    output logic              host_swap_ack,
    output logic              front_bank,
    // Framebuffer RAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    hub75_swap_state_t state;

    logic              rd_issued;   // a read was presented to the RAM this cycle
    logic [DATA_W-1:0] rd_hold;     // last returned pixel, shown between valids
    logic              host_fire;

    // The display never stalls; the host only gets idle cycles, and none while
    // a swap is waiting, so the back bank is frozen once it has been published.
    assign host_wr_ready     = !disp_rd_en && (state == SW_IDLE);
    assign host_fire         = host_wr_valid && host_wr_ready;
    assign host_swap_pending = (state == SW_PEND);

    // Read data comes straight off the RAM on the valid cycle and is held after.
    assign disp_rd_data = disp_rd_valid ? mem_rdata : rd_hold;

    // Register the granted access onto the RAM port (address/data hold when idle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (disp_rd_en) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {front_bank, disp_rd_addr};
        end else if (host_fire) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {~front_bank, host_wr_addr};
            mem_wdata <= host_wr_data;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // Track reads through issue and RAM latency; keep the last pixel on hand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_issued     <= 1'b0;
            disp_rd_valid <= 1'b0;
            rd_hold       <= '0;
        end else begin
            rd_issued     <= disp_rd_en;
            disp_rd_valid <= rd_issued;
            if (disp_rd_valid) begin
                rd_hold <= mem_rdata;
            end
        end
    end

    // Bank-swap FSM: a request waits for the next frame boundary, then flips
    // the banks, acknowledges once and unlocks the display for good.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SW_IDLE;
            front_bank    <= 1'b0;
            host_swap_ack <= 1'b0;
            disp_enable   <= 1'b0;
        end else begin
            host_swap_ack <= 1'b0;
            case (state)
                SW_IDLE: begin
                    // A frame_done arriving with the request is deliberately
                    // not used: the swap waits for a later boundary.
                    if (host_swap_req) begin
                        state <= SW_PEND;
                    end
                end
                SW_PEND: begin
                    if (disp_frame_done) begin
                        front_bank    <= ~front_bank;
                        host_swap_ack <= 1'b1;
                        disp_enable   <= 1'b1;
                        state         <= SW_IDLE;
                    end
                end
                default: begin
                    state <= SW_IDLE;
                end
            endcase
        end
    end

endmodule : hub75_fb_scheduler
`default_nettype wire

// File: tb/tb_hub75_fb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_fb_scheduler
// Desc     : Self-checking bench for hub75_fb_scheduler with a transaction-level
//            reference model (shadow framebuffer, read-return queue, bank flag).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub75_fb_scheduler;

    localparam int AW = 12;
    localparam int DW = 48;

    logic          clk;
    logic          rst;
    logic          disp_rd_en;
    logic [AW-1:0] disp_rd_addr;
    logic [DW-1:0] disp_rd_data;
    logic          disp_rd_valid;
    logic          disp_frame_done;
    logic          disp_enable;
    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_swap_req;
    logic          host_swap_pending;
    logic          host_swap_ack;
    logic          front_bank;
    logic          mem_en;
    logic          mem_we;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    hub75_fb_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .disp_rd_en        (disp_rd_en),
        .disp_rd_addr      (disp_rd_addr),
        .disp_rd_data      (disp_rd_data),
        .disp_rd_valid     (disp_rd_valid),
        .disp_frame_done   (disp_frame_done),
        .disp_enable       (disp_enable),
        .host_wr_valid     (host_wr_valid),
        .host_wr_ready     (host_wr_ready),
        .host_wr_addr      (host_wr_addr),
        .host_wr_data      (host_wr_data),
        .host_swap_req     (host_swap_req),
        .host_swap_pending (host_swap_pending),
        .host_swap_ack     (host_swap_ack),
        .front_bank        (front_bank),
        .mem_en            (mem_en),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer RAM: single port, one-cycle read latency.
    logic [DW-1:0] ram [0:(1<<(AW+1))-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return {16'(i * 7 + 3), 16'(~i), 16'(i ^ 16'h5a5a)};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] shadow [0:(1<<(AW+1))-1];
    rd_t           rq[$];
    int            cyc;
    logic          m_front, m_pend, m_enable, e_ack;
    logic          e_en, e_we;
    logic [AW:0]   e_addr;
    logic [DW-1:0] e_wdata, m_last;
    logic          last_fire;
    int            valid_seen;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_front  = 1'b0;
        m_pend   = 1'b0;
        m_enable = 1'b0;
        e_ack    = 1'b0;
        e_en     = 1'b0;
        e_we     = 1'b0;
        e_addr   = '0;
        e_wdata  = '0;
        m_last   = '0;
        rq.delete();
    endtask

    task automatic check_outputs();
        logic          exp_v;
        logic [DW-1:0] exp_d;
        exp_v = 1'b0;
        exp_d = m_last;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_v  = 1'b1;
            exp_d  = rq[0].data;
            m_last = exp_d;
            void'(rq.pop_front());
        end
        if (disp_rd_valid === 1'b1) valid_seen++;
        chk("mem_en",       mem_en,            e_en);
        chk("mem_we",       mem_we,            e_we);
        chk("mem_addr",     mem_addr,          e_addr);
        chk("mem_wdata",    mem_wdata,         e_wdata);
        chk("front_bank",   front_bank,        m_front);
        chk("swap_ack",     host_swap_ack,     e_ack);
        chk("swap_pending", host_swap_pending, m_pend);
        chk("disp_enable",  disp_enable,       m_enable);
        chk("rd_valid",     disp_rd_valid,     exp_v);
        chk("rd_data",      disp_rd_data,      exp_d);
    endtask

    // One clock cycle: drive, check the combinational grant, predict, advance, check.
    task automatic step(input logic rd, input logic [AW-1:0] ra,
                        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic sw, input logic fd);
        logic exp_ready, fire;
        disp_rd_en      = rd;
        disp_rd_addr    = ra;
        host_wr_valid   = wv;
        host_wr_addr    = wa;
        host_wr_data    = wd;
        host_swap_req   = sw;
        disp_frame_done = fd;
        #1;
        exp_ready = !rd && !m_pend;
        chk("wr_ready", host_wr_ready, exp_ready);
        fire = wv && exp_ready;
        if (rd) begin
            e_en   = 1'b1;
            e_we   = 1'b0;
            e_addr = {m_front, ra};
            rq.push_back('{due: cyc + 2, data: shadow[{m_front, ra}]});
        end else if (fire) begin
            e_en    = 1'b1;
            e_we    = 1'b1;
            e_addr  = {~m_front, wa};
            e_wdata = wd;
            shadow[{~m_front, wa}] = wd;
        end else begin
            e_en = 1'b0;
            e_we = 1'b0;
        end
        e_ack = 1'b0;
        if (m_pend && fd) begin
            m_front  = ~m_front;
            m_pend   = 1'b0;
            m_enable = 1'b1;
            e_ack    = 1'b1;
        end else if (!m_pend && sw) begin
            m_pend = 1'b1;
        end
        last_fire = fire;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        disp_rd_en      = 1'b0;
        host_wr_valid   = 1'b0;
        host_swap_req   = 1'b0;
        disp_frame_done = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          have_w;
        logic [AW-1:0] pw_a;
        logic [DW-1:0] pw_d;

        for (int i = 0; i < (1 << (AW + 1)); i++) begin
            ram[i]   <= init_word(i);
            shadow[i] = init_word(i);
        end
        rst             = 1'b1;
        disp_rd_en      = 1'b0;
        disp_rd_addr    = '0;
        host_wr_valid   = 1'b0;
        host_wr_addr    = '0;
        host_wr_data    = '0;
        host_swap_req   = 1'b0;
        disp_frame_done = 1'b0;
        cyc             = 0;
        valid_seen      = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_ready_idle", host_wr_ready, 1'b1);
        rst = 1'b0;

        // Single read of pixel 5 from bank 0.
        step(1'b1, 12'h005, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("rd5_addr", mem_addr, 13'h0005);
        idle(3);

        // 64-cycle read burst: one valid per cycle.
        valid_seen = 0;
        for (int i = 0; i < 64; i++) step(1'b1, 12'(i * 3), 1'b0, '0, '0, 1'b0, 1'b0);
        idle(2);
        chk("burst_valids", valid_seen, 64);

        // Host write held off by three display reads, then accepted into bank 1.
        for (int i = 0; i < 3; i++) step(1'b1, 12'(i), 1'b1, 12'h123, 48'hABCDEF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 12'h123, 48'hABCDEF, 1'b0, 1'b0);
        chk("wr_addr_back", mem_addr, 13'h1123);
        chk("wr_we", mem_we, 1'b1);
        idle(1);

        // Swap request, frame boundary ten cycles later.
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b1, 12'h044, 48'h1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 12'h044, 48'h1, 1'b0, 1'b1);
        chk("swap_front1", front_bank, 1'b1);
        chk("swap_enable", disp_enable, 1'b1);
        step(1'b0, '0, 1'b1, 12'h123, 48'h777, 1'b0, 1'b0);
        chk("post_swap_wr_bank", mem_addr[AW], 1'b0);
        // Read back the host pixel now that bank 1 is displayed.
        step(1'b1, 12'h123, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(2);
        chk("published_pixel", m_last, 48'hABCDEF);

        // Request coincident with frame_done, then a redundant request.
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk("coincident_no_ack", host_swap_ack, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("wrap_front0", front_bank, 1'b0);
        idle(3);

        // Randomised traffic; host keeps an unaccepted write stable.
        have_w = 1'b0;
        pw_a   = '0;
        pw_d   = '0;
        for (int i = 0; i < 800; i++) begin
            if (!have_w && ($urandom_range(0, 9) < 6)) begin
                have_w = 1'b1;
                pw_a   = 12'($urandom);
                pw_d   = {16'($urandom), 32'($urandom)};
            end
            step(1'($urandom_range(0, 1)), 12'($urandom), have_w, pw_a, pw_d,
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 11) == 0));
            if (last_fire) have_w = 1'b0;
        end
        idle(3);

        // Reset while a swap is pending and reads are in flight.
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 12'(i + 100), 1'b0, '0, '0, 1'b0, 1'b0);
        async_reset();
        chk("rst_front0", front_bank, 1'b0);
        chk("rst_pending0", host_swap_pending, 1'b0);
        valid_seen = 0;
        idle(4);
        chk("rst_no_valid", valid_seen, 0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("rst_swap_dropped", host_swap_ack, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_hub75_fb_scheduler
`default_nettype wire
